sad_accum_min: RTL
==================

SAD_ACCUM_MIN -- requirements
Module: sad_accum_min

Interface
REQ-001 SHALL have clk, input, 1: the single clock; all state changes on its rising edge.
REQ-002 SHALL have rst_n, input, 1: reset, asynchronous and active-low.
REQ-003 SHALL have clear, input, 1: synchronous abort to IDLE.
REQ-004 SHALL have in_valid, input, 1: diff_in holds one line of absolute differences.
REQ-005 SHALL have in_ready, output, 1: the block can accept a line.
REQ-006 SHALL have diff_in, input, 1200: 25 candidates of 48 bits each (6 pixels, 8-bit unsigned).
- Candidate k occupies bits [48k+47:48k].
- k = 5*row + col.
- row order: UH=0, UQ=1, M=2, LQ=3, LH=4.
- col order: h=0, q=1, f=2, r=3, i=4.
REQ-007 SHALL have out_valid, output, 1: a result is held.
REQ-008 SHALL have out_ready, input, 1: the consumer takes the result.
REQ-009 SHALL have best_idx, output, 5: winning candidate index, 0..24.
REQ-010 SHALL have best_sad, output, 14: SAD of the winning candidate.

Function
REQ-011 SHALL implement states IDLE, ACCUM, SEARCH, HOLD.
REQ-012 SHALL define a line transfer as in_valid && in_ready on a clock edge.
REQ-013 SHALL drive in_ready high in IDLE and ACCUM only.
REQ-014 SHALL, for each candidate, sum its 6 pixel bytes zero-extended: per-line sum max 1530, 11 bits.
REQ-015 SHALL hold 25 accumulators of 14 bits each; maximum 36*255 = 9180, so no overflow.
REQ-016 SHALL load the accumulators with the per-line sum on the first transfer from IDLE; the state then goes to ACCUM with line count 1.
REQ-017 SHALL add the per-line sum on each later transfer in ACCUM.
REQ-018 SHALL go to SEARCH with scan index 0 on the 6th transfer.
REQ-019 SHALL compare one accumulator per cycle in SEARCH, indices 0..24, in exactly 25 cycles.
REQ-020 SHALL make candidate 0 the initial best; a later candidate replaces it only if its SAD is strictly smaller (lowest index wins ties, see REQ-030).
REQ-021 SHALL go to HOLD after index 24 is compared, with out_valid high.
- Latency: 6th transfer at edge T gives out_valid high after edge T+26.
REQ-022 SHALL hold best_idx and best_sad stable while out_valid is high.
REQ-023 SHALL go to IDLE on the edge where out_valid && out_ready; the next frame's first line is accepted one cycle later.
REQ-024 SHALL let clear return the block to IDLE from any state on the next edge.
- out_valid drops; the line count resets.
- If clear and a transfer occur on the same edge, clear wins and the line is discarded.
REQ-025 SHALL ignore in_valid while in SEARCH or HOLD; no line is lost because in_ready is low then.

Reset
REQ-026 SHALL, while rst_n is low, asynchronously force:
- state IDLE, line count 0, scan index 0;
- in_ready = 0, out_valid = 0;
- best_idx = 0, best_sad = 0;
- all accumulators 0.
REQ-027 SHALL raise in_ready on the first clock edge after rst_n deasserts.
REQ-028 SHALL, if reset asserts mid-frame or mid-search, discard the partial result with no out_valid pulse.

Configuration
REQ-029 SHALL recognise macro SAD_CENTER_BIAS_EN.
REQ-030 SHALL, without SAD_CENTER_BIAS_EN, resolve ties to the lowest index.
REQ-031 SHALL, with SAD_CENTER_BIAS_EN defined, resolve any tie involving candidate 12 (M_f, zero displacement) to 12.
- Other ties still resolve to the lowest index.
- Latency is unchanged.

Structure
REQ-032 SHALL place in the shared package:
- constants NUM_CAND=25, PIX_PER_LINE=6, LINES=6, CENTER_IDX=12;
- SAD width 14, line-sum width 11;
- the state enum.
REQ-033 SHALL use one sub-module, line_sum6: combinational sum of 6 bytes to 11 bits, instantiated 25 times.

Verification
REQ-034 SHALL cover: all bytes 0 except candidate 7 = 1, 6 lines -> best_idx=0, best_sad=0; all bytes equal 1 -> every SAD 36, best_idx=0 (macro off) or 12 (macro on).
REQ-035 SHALL cover: candidate k bytes = 25-k, 6 lines -> best_idx=24, best_sad=36.
REQ-036 SHALL cover: all bytes 255, 6 lines -> best_sad=9180, no wrap.
REQ-037 SHALL cover: in_valid held high across a frame -> exactly 6 transfers; in_ready low for 25 SEARCH cycles plus HOLD; out_valid rises 26 cycles after the 6th transfer.
REQ-038 SHALL cover: out_ready low for 10 cycles -> outputs stable, in_ready low; clear after the 3rd line -> IDLE and no out_valid; rst_n low during SEARCH -> all outputs 0 immediately.

Source files
------------

// File: rtl/sad_accum_min_pkg.sv
// Shared constants, state encoding and result payload for the SAD accumulate/min-search block.
package sad_accum_min_pkg;

  localparam int unsigned NUM_CAND     = 25;
  localparam int unsigned PIX_PER_LINE = 6;
  localparam int unsigned LINES        = 6;
  localparam int unsigned CENTER_IDX   = 12;
  localparam int unsigned PIX_W        = 8;
  localparam int unsigned SAD_W        = 14;
  localparam int unsigned LSUM_W       = 11;
  localparam int unsigned CAND_W       = PIX_PER_LINE * PIX_W;
  localparam int unsigned DIFF_W       = NUM_CAND * CAND_W;
  localparam int unsigned IDX_W        = 5;
  localparam int unsigned LCNT_W       = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    SEARCH = 2'd2,
    HOLD   = 2'd3
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [SAD_W-1:0] sad;
  } result_t;

endpackage

// File: rtl/sad_accum_min_line_sum6.sv
// Combinational sum of one candidate's six absolute-difference bytes.
module line_sum6
  import sad_accum_min_pkg::*;
(
  input  logic [CAND_W-1:0] pix_i,
  output logic [LSUM_W-1:0] sum_o_c
);

  always_comb begin
    sum_o_c = '0;
    for (int unsigned p = 0; p < PIX_PER_LINE; p++) begin
      sum_o_c = sum_o_c + LSUM_W'(pix_i[p*PIX_W +: PIX_W]);
    end
  end

endmodule

// File: rtl/sad_accum_min.sv
// Accumulates 6 lines of SAD for 25 candidates, then scans for the minimum.
// Optional macro SAD_CENTER_BIAS_EN: ties involving candidate 12 resolve to 12.
module sad_accum_min
  import sad_accum_min_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIFF_W-1:0] diff_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  best_idx,
  output logic [SAD_W-1:0]  best_sad
);

  localparam logic [LCNT_W-1:0] LAST_LINE = LCNT_W'(LINES - 1);
  localparam logic [IDX_W-1:0]  SCAN_DONE = IDX_W'(NUM_CAND);

  state_e            state_q, state_d;
  logic [LCNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [IDX_W-1:0]  scan_q, scan_d;
  result_t           best_q, best_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [SAD_W-1:0]  acc_q [NUM_CAND];
  logic [SAD_W-1:0]  acc_d [NUM_CAND];
  logic [LSUM_W-1:0] lsum  [NUM_CAND];
  logic              xfer, load_acc, add_acc, take;
  logic [SAD_W-1:0]  scan_sad;

  for (genvar k = 0; k < NUM_CAND; k++) begin : g_sum
    line_sum6 u_sum (
      .pix_i   (diff_in[k*CAND_W +: CAND_W]),
      .sum_o_c (lsum[k])
    );
  end

  assign xfer     = in_valid && in_ready_q;
  assign scan_sad = acc_q[scan_q];

  // Strict-less replacement keeps the lowest index on ties.
  always_comb begin
`ifdef SAD_CENTER_BIAS_EN
    take = (scan_sad < best_q.sad) ||
           ((scan_q == IDX_W'(CENTER_IDX)) && (scan_sad == best_q.sad));
`else
    take = (scan_sad < best_q.sad);
`endif
  end

  always_comb begin
    state_d    = state_q;
    line_cnt_d = line_cnt_q;
    scan_d     = scan_q;
    best_d     = best_q;
    load_acc   = 1'b0;
    add_acc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          load_acc   = 1'b1;
          line_cnt_d = LCNT_W'(1);
          state_d    = ACCUM;
        end
      end
      ACCUM: begin
        if (xfer) begin
          add_acc = 1'b1;
          if (line_cnt_q == LAST_LINE) begin
            line_cnt_d = '0;
            scan_d     = '0;
            state_d    = SEARCH;
          end else begin
            line_cnt_d = line_cnt_q + LCNT_W'(1);
          end
        end
      end
      SEARCH: begin
        if (scan_q == SCAN_DONE) begin
          state_d = HOLD;
        end else begin
          if ((scan_q == '0) || take) begin
            best_d = '{idx: scan_q, sad: scan_sad};
          end
          scan_d = scan_q + IDX_W'(1);
        end
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d    = IDLE;
      line_cnt_d = '0;
      scan_d     = '0;
      load_acc   = 1'b0;
      add_acc    = 1'b0;
    end
    in_ready_d  = (state_d == IDLE) || (state_d == ACCUM);
    out_valid_d = (state_d == HOLD);
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_CAND; k++) begin
      acc_d[k] = acc_q[k];
      if (load_acc)     acc_d[k] = SAD_W'(lsum[k]);
      else if (add_acc) acc_d[k] = acc_q[k] + SAD_W'(lsum[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      line_cnt_q  <= '0;
      scan_q      <= '0;
      best_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      for (int unsigned k = 0; k < NUM_CAND; k++) acc_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      line_cnt_q  <= line_cnt_d;
      scan_q      <= scan_d;
      best_q      <= best_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      for (int unsigned k = 0; k < NUM_CAND; k++) acc_q[k] <= acc_d[k];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign best_idx  = best_q.idx;
  assign best_sad  = best_q.sad;

endmodule
